// File: rtl/sipo_reg.sv
// Serial-in/parallel-out register for the UART RX path: shifts LSB-first, presents the word on load.
// Optional SIPO_CNT_EN adds a saturating shift counter and a frame_full flag.
module sipo_reg #(
    parameter  int WIDTH = 9,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             reg_clk,
    input  logic             reg_rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             serial_data_in,
    output logic [WIDTH-1:0] parallel_data_out,
    output logic             out_valid
`ifdef SIPO_CNT_EN
    ,
    output logic [CW-1:0]    shift_cnt,
    output logic             frame_full
`endif
);

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] pdo_q;
    logic             vld_q;

    // Newest bit enters at the MSB so the first bit received ends up in bit 0.
    always_comb begin
        sreg_d            = sreg_q >> 1;
        sreg_d[WIDTH-1]   = serial_data_in;
    end

    always_ff @(posedge reg_clk or negedge reg_rst_n) begin
        if (!reg_rst_n) begin
            sreg_q <= '0;
            pdo_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= load;
            if (load)
                pdo_q <= sreg_q;
            else if (shift)
                sreg_q <= sreg_d;
        end
    end

    assign parallel_data_out = pdo_q;
    assign out_valid         = vld_q;

`ifdef SIPO_CNT_EN
    logic [CW-1:0] cnt_q;

    always_ff @(posedge reg_clk or negedge reg_rst_n) begin
        if (!reg_rst_n)
            cnt_q <= '0;
        else if (load)
            cnt_q <= '0;
        else if (shift && (cnt_q != CW'(WIDTH)))
            cnt_q <= cnt_q + CW'(1);
    end

    assign shift_cnt  = cnt_q;
    assign frame_full = (cnt_q == CW'(WIDTH));
`endif

endmodule

// File: tb/tb_sipo_reg.sv
// Scoreboard bench for sipo_reg: loaded words are queued from a reference model and popped on out_valid.
// Exercises the SIPO_CNT_EN counter when that macro is defined.
module tb_sipo_reg;
    localparam int W  = 9;
    localparam int CW = $clog2(W + 1);

    logic          reg_clk = 1'b0;
    logic          reg_rst_n;
    logic          load, shift, serial_data_in;
    logic [W-1:0]  parallel_data_out;
    logic          out_valid;
`ifdef SIPO_CNT_EN
    logic [CW-1:0] shift_cnt;
    logic          frame_full;
`endif

    sipo_reg #(.WIDTH(W)) dut (
        .reg_clk           (reg_clk),
        .reg_rst_n         (reg_rst_n),
        .load              (load),
        .shift             (shift),
        .serial_data_in    (serial_data_in),
        .parallel_data_out (parallel_data_out),
        .out_valid         (out_valid)
`ifdef SIPO_CNT_EN
        ,
        .shift_cnt         (shift_cnt),
        .frame_full        (frame_full)
`endif
    );

    always #5 reg_clk = ~reg_clk;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] exp_sreg = '0;
    logic [W-1:0] exp_out  = '0;
    int           exp_cnt  = 0;
    logic [W-1:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_sreg = '0;
        exp_out  = '0;
        exp_cnt  = 0;
        sb_q.delete();
    endtask

    // Drive one edge, advance the model, then check at the following falling edge.
    task automatic step(input logic ld, input logic sh, input logic din);
        load = ld; shift = sh; serial_data_in = din;
        @(posedge reg_clk);
        if (ld) begin
            sb_q.push_back(exp_sreg);
            exp_out = exp_sreg;
            exp_cnt = 0;
        end else if (sh) begin
            exp_sreg = {din, exp_sreg[W-1:1]};
            if (exp_cnt < W) exp_cnt++;
        end
        @(negedge reg_clk);
        chk("out_valid", 32'(out_valid), 32'(ld));
        if (out_valid) begin
            if (sb_q.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
            else                  chk("sb_word", 32'(parallel_data_out), 32'(sb_q.pop_front()));
        end
        chk("pdo_hold", 32'(parallel_data_out), 32'(exp_out));
`ifdef SIPO_CNT_EN
        chk("shift_cnt", 32'(shift_cnt), 32'(exp_cnt));
        chk("frame_full", 32'(frame_full), 32'(exp_cnt == W));
`endif
        load = 1'b0; shift = 1'b0;
    endtask

    logic [W-1:0] frame;
    logic [W-1:0] prio_word;

    initial begin
        reg_rst_n = 1'b0; load = 1'b0; shift = 1'b1; serial_data_in = 1'b1;
        // Reset holds everything cleared even with shift active and a 1 on the line.
        for (int i = 0; i < 4; i++) begin
            @(negedge reg_clk);
            chk("rst_pdo", 32'(parallel_data_out), 32'(0));
            chk("rst_vld", 32'(out_valid), 32'(0));
`ifdef SIPO_CNT_EN
            chk("rst_cnt", 32'(shift_cnt), 32'(0));
`endif
        end
        shift = 1'b0;
        reg_rst_n = 1'b1;
        model_reset();

        // Frame capture: bits 1,0,1,1,0,1,0,0,1 in time order -> 0x12D.
        frame = 9'b1_0010_1101;
        for (int i = 0; i < W; i++) step(1'b0, 1'b1, frame[i]);
        chk("pre_load_pdo", 32'(parallel_data_out), 32'(0));
        step(1'b1, 1'b0, 1'b0);
        chk("capture_12d", 32'(parallel_data_out), 32'h12D);
        step(1'b0, 1'b0, 1'b0);
        chk("vld_one_cycle", 32'(out_valid), 32'(0));

        // Hold with a toggling line.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'(i));
        chk("hold_12d", 32'(parallel_data_out), 32'h12D);

        // Priority: perturb sreg, then load+shift with din=0, then load only.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        prio_word = parallel_data_out;
        chk("prio_word", 32'(prio_word), 32'h1E5);
        step(1'b1, 1'b0, 1'b1);
        chk("prio_reload", 32'(parallel_data_out), 32'(prio_word));

        // Async reset between edges after 4 shifts.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
        #2 reg_rst_n = 1'b0;
        #1;
        chk("async_rst_pdo", 32'(parallel_data_out), 32'(0));
        chk("async_rst_vld", 32'(out_valid), 32'(0));
        model_reset();
        #1 reg_rst_n = 1'b1;
        for (int i = 0; i < W; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("all_ones", 32'(parallel_data_out), 32'h1FF);

        // Overrun: more than W shifts drops the oldest bits.
        for (int i = 0; i < W + 3; i++) step(1'b0, 1'b1, 1'(i % 3 == 0));
`ifdef SIPO_CNT_EN
        chk("cnt_saturate", 32'(shift_cnt), 32'(W));
        chk("full_saturate", 32'(frame_full), 32'(1));
`endif
        step(1'b1, 1'b0, 1'b0);
        chk("overrun_word", 32'(parallel_data_out), 32'h049);
`ifdef SIPO_CNT_EN
        chk("cnt_clear", 32'(shift_cnt), 32'(0));
        chk("full_clear", 32'(frame_full), 32'(0));
        for (int i = 0; i < W; i++) step(1'b0, 1'b1, 1'b0);
        chk("cnt_nine", 32'(shift_cnt), 32'(W));
        chk("full_nine", 32'(frame_full), 32'(1));
`endif

        step(1'b0, 1'b0, 1'b0);
        chk("sb_drained", 32'(sb_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
